tx_frame_arbiter: RTL and testbench

- Shares the single UART byte transmitter between NREQ message sources, such as ID reply, start acknowledge, PPR report, data stream and stop frames.
- Arbitrates round-robin and latches the winner's frame, up to MAXLEN bytes.
- Sequences the frame byte by byte over the transmitter's start/done handshake, with a watchdog on each byte.
- Sits between the per-command message builders and the byte-level UART/metronome pair.

---
 rtl/tx_frame_arbiter_if.sv | 27 ++
 rtl/tx_frame_arbiter.sv | 174 +++++++++++++++++
 tb/tb_tx_frame_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_frame_arbiter_if.sv
// Bus bundle between the per-command message builders and the frame arbiter,
// plus the byte-level start/done handshake toward the UART transmitter.
interface tx_frame_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int MAXLEN = 6
);
  logic [NREQ-1:0]          Req;
  logic [NREQ*3-1:0]        ReqLen;
  logic [NREQ*MAXLEN*8-1:0] ReqPayload;
  logic [NREQ-1:0]          Grant;
  logic [NREQ-1:0]          FrameDone;
  logic                     ByteStart;
  logic [7:0]               ByteData;
  logic                     ByteDone;
  logic                     Busy;
  logic                     TimeoutErr;

  modport master (
    output Req, ReqLen, ReqPayload, ByteDone,
    input  Grant, FrameDone, ByteStart, ByteData, Busy, TimeoutErr
  );

  modport slave (
    input  Req, ReqLen, ReqPayload, ByteDone,
    output Grant, FrameDone, ByteStart, ByteData, Busy, TimeoutErr
  );
endinterface

// File: rtl/tx_frame_arbiter.sv
// Round-robin frame arbiter sequencing latched frames onto a byte transmitter.
// Optional: define TERMINATOR_EN to append two 8'h2E bytes to every frame.
module tx_frame_arbiter #(
  parameter int NREQ    = 4,
  parameter int MAXLEN  = 6,
  parameter int TIMEOUT = 4095
) (
  input logic               Clk,
  input logic               nRst,
  tx_frame_arbiter_if.slave bus
);
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

`ifdef TERMINATOR_EN
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, TERM1, TERM2, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_t;
`endif

  state_t              state;
  logic [IDXW-1:0]     rrPtr;
  logic [IDXW-1:0]     winner;
  logic [IDXW-1:0]     pick;
  logic [IDXW-1:0]     cand;
  logic                anyReq;
  logic [2:0]          pickLen;
  logic [2:0]          frameLen;
  logic [2:0]          idx;
  logic [MAXLEN*8-1:0] pickPayload;
  logic [MAXLEN*8-1:0] shadow;
  logic [CNTW-1:0]     waitCnt;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     frameDone;
  logic                byteStart;
  logic [7:0]          byteData;
  logic                busy;
  logic                timeoutErr;
`ifdef TERMINATOR_EN
  logic [1:0]          termCnt;
`endif

  // First set request searching upward from the slot after the last winner.
  always_comb begin
    anyReq = 1'b0;
    pick   = '0;
    cand   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDXW'((32'(rrPtr) + k) % 32'(NREQ));
      if (!anyReq && bus.Req[cand]) begin
        anyReq = 1'b1;
        pick   = cand;
      end
    end
    pickPayload = bus.ReqPayload[int'(pick)*MAXLEN*8 +: MAXLEN*8];
    pickLen     = bus.ReqLen[int'(pick)*3 +: 3];
    if (pickLen > 3'(MAXLEN)) pickLen = 3'(MAXLEN);
  end

  // Frame is captured on the IDLE->LOAD edge so byte 0 is ready for ISSUE.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state      <= IDLE;
      rrPtr      <= IDXW'(NREQ - 1);
      winner     <= '0;
      frameLen   <= '0;
      idx        <= '0;
      shadow     <= '0;
      waitCnt    <= '0;
      grant      <= '0;
      frameDone  <= '0;
      byteStart  <= 1'b0;
      byteData   <= '0;
      busy       <= 1'b0;
      timeoutErr <= 1'b0;
`ifdef TERMINATOR_EN
      termCnt    <= '0;
`endif
    end else begin
      byteStart  <= 1'b0;
      frameDone  <= '0;
      timeoutErr <= 1'b0;
      case (state)
        IDLE: if (anyReq) begin
          winner   <= pick;
          grant    <= NREQ'(1) << pick;
          shadow   <= pickPayload;
          frameLen <= pickLen;
          idx      <= '0;
          busy     <= 1'b1;
`ifdef TERMINATOR_EN
          termCnt  <= '0;
`endif
          state    <= LOAD;
        end
        LOAD: begin
          if (frameLen == 3'd0) begin
`ifdef TERMINATOR_EN
            termCnt   <= 2'd1;
            byteStart <= 1'b1;
            byteData  <= 8'h2E;
            state     <= TERM1;
`else
            frameDone <= grant;
            grant     <= '0;
            state     <= DONE;
`endif
          end else begin
            byteStart <= 1'b1;
            byteData  <= shadow[7:0];
            state     <= ISSUE;
          end
        end
`ifdef TERMINATOR_EN
        ISSUE, TERM1, TERM2: begin
`else
        ISSUE: begin
`endif
          waitCnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (bus.ByteDone) begin
`ifdef TERMINATOR_EN
            if (termCnt == 2'd2) begin
              frameDone <= grant;
              grant     <= '0;
              state     <= DONE;
            end else if (termCnt == 2'd1 || idx == frameLen - 3'd1) begin
              termCnt   <= termCnt + 2'd1;
              byteStart <= 1'b1;
              byteData  <= 8'h2E;
              state     <= (termCnt == 2'd1) ? TERM2 : TERM1;
            end
`else
            if (idx == frameLen - 3'd1) begin
              frameDone <= grant;
              grant     <= '0;
              state     <= DONE;
            end
`endif
            else begin
              idx       <= idx + 3'd1;
              byteStart <= 1'b1;
              byteData  <= shadow[8*(int'(idx)+1) +: 8];
              state     <= ISSUE;
            end
          end else if (waitCnt == CNTW'(TIMEOUT - 1)) begin
            timeoutErr <= 1'b1;
            grant      <= '0;
            busy       <= 1'b0;
            rrPtr      <= winner;
            state      <= IDLE;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        DONE: begin
          rrPtr <= winner;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Grant      = grant;
  assign bus.FrameDone  = frameDone;
  assign bus.ByteStart  = byteStart;
  assign bus.ByteData   = byteData;
  assign bus.Busy       = busy;
  assign bus.TimeoutErr = timeoutErr;
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter: a scoreboard queues expected bytes and
// winners as frames are requested; monitors pop and compare as the DUT emits them.
module tb_tx_frame_arbiter;
  localparam int NREQ    = 4;
  localparam int MAXLEN  = 6;
  localparam int TIMEOUT = 20;

  logic Clk = 1'b0;
  logic nRst;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   startCount = 0;
  bit   respond = 1'b1;
  bit   glitch = 1'b0;
  bit   autoDrop = 1'b1;
  logic [NREQ-1:0] lastGrant = '0;

  logic [7:0] pl [NREQ][MAXLEN];
  int         ln [NREQ];
  logic [7:0] expByte [$];
  int         expDone [$];

  tx_frame_arbiter_if #(.NREQ(NREQ), .MAXLEN(MAXLEN)) bus ();

  tx_frame_arbiter #(.NREQ(NREQ), .MAXLEN(MAXLEN), .TIMEOUT(TIMEOUT)) dut (
    .Clk  (Clk),
    .nRst (nRst),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte 0 is the most significant byte of 'bytes'.
  task automatic setReq(input int i, input int len, input logic [47:0] bytes);
    ln[i] = len;
    bus.ReqLen[3*i +: 3] = 3'(len);
    for (int k = 0; k < MAXLEN; k++) begin
      pl[i][k] = bytes[47-8*k -: 8];
      bus.ReqPayload[(i*MAXLEN+k)*8 +: 8] = bytes[47-8*k -: 8];
    end
  endtask

  task automatic pushFrame(input int i);
    int n;
    n = (ln[i] > MAXLEN) ? MAXLEN : ln[i];
    for (int k = 0; k < n; k++) expByte.push_back(pl[i][k]);
`ifdef TERMINATOR_EN
    expByte.push_back(8'h2E);
    expByte.push_back(8'h2E);
`endif
    expDone.push_back(i);
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge Clk); #1;
      n++;
    end while ((bus.Busy || expDone.size() != 0 || expByte.size() != 0) && n < 3000);
    chk(tag, 64'(bus.Busy || expDone.size() != 0 || expByte.size() != 0), 64'(0));
  endtask

  // Transmitter model: ByteDone some cycles after each ByteStart.
  initial begin : responder
    int cnt;
    cnt = -1;
    bus.ByteDone = 1'b0;
    forever begin
      @(negedge Clk);
      bus.ByteDone = 1'b0;
      if (!nRst) cnt = -1;
      else if (bus.ByteStart) begin
        cnt = 10;
        if (glitch) bus.ByteDone = 1'b1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && respond) bus.ByteDone = 1'b1;
      end
    end
  end

  // Scoreboard consumer and requester model (drops Req when its frame ends).
  initial begin : monitor
    logic [NREQ-1:0] prevGrant;
    int w;
    prevGrant = '0;
    forever begin
      @(negedge Clk);
      if (nRst === 1'b1) begin
        if (bus.ByteStart) begin
          startCount++;
          chk("ByteStart_expected", 64'(expByte.size() > 0), 64'(1));
          if (expByte.size() > 0) chk("ByteData", 64'(bus.ByteData), 64'(expByte.pop_front()));
        end
        if (bus.FrameDone != '0) begin
          chk("FrameDone_expected", 64'(expDone.size() > 0), 64'(1));
          if (expDone.size() > 0) begin
            w = expDone.pop_front();
            chk("FrameDone_winner", 64'(bus.FrameDone), 64'(4'b0001 << w));
          end
          chk("Grant_at_done", 64'(bus.Grant), 64'(0));
          if (autoDrop) bus.Req = bus.Req & ~bus.FrameDone;
        end
        if (bus.Grant != prevGrant && bus.Grant != '0) begin
          chk("Grant_onehot", 64'($onehot(bus.Grant)), 64'(1));
          lastGrant = bus.Grant;
        end
        if (bus.TimeoutErr && autoDrop) bus.Req = bus.Req & ~lastGrant;
        prevGrant = bus.Grant;
      end else begin
        prevGrant = '0;
      end
    end
  end

  initial begin : stimulus
    int n;
    int t0;
    nRst = 1'b0;
    bus.Req = '0;
    bus.ReqLen = '0;
    bus.ReqPayload = '0;
    for (int i = 0; i < NREQ; i++) setReq(i, 1, 48'hA0_00_00_00_00_00 | (48'(i) << 40));
    repeat (3) @(negedge Clk);
    #1;
    chk("reset_outputs", 64'({bus.Grant, bus.FrameDone, bus.ByteStart, bus.ByteData,
                              bus.Busy, bus.TimeoutErr}), 64'(0));
    nRst = 1'b1;
    @(negedge Clk); #1;

    // Round-robin with 0,1,3 held
    autoDrop = 1'b0;
    for (int r = 0; r < 2; r++) begin
      pushFrame(0); pushFrame(1); pushFrame(3);
    end
    bus.Req = 4'b1011;
    n = 0;
    do begin @(negedge Clk); #1; n++; end while (expDone.size() != 0 && n < 1000);
    bus.Req = '0;
    autoDrop = 1'b1;
    waitIdle("rr_order_complete");

    // Single request, latency and payload order
    setReq(1, 3, 48'h48_65_6C_00_00_00);
    pushFrame(1);
    bus.Req = 4'b0010;
    @(negedge Clk); #1;
    chk("grant_latency", 64'(bus.Grant), 64'(4'b0010));
    @(negedge Clk); #1;
    chk("first_start_latency", 64'(bus.ByteStart), 64'(1));
    waitIdle("single_frame");
    chk("single_busy_low", 64'(bus.Busy), 64'(0));

    // Zero-length frame
    startCount = 0;
    setReq(0, 0, 48'hEE_EE_EE_EE_EE_EE);
    pushFrame(0);
    bus.Req = 4'b0001;
    waitIdle("len0_frame");
`ifdef TERMINATOR_EN
    chk("len0_starts", 64'(startCount), 64'(2));
`else
    chk("len0_starts", 64'(startCount), 64'(0));
`endif

    // Overlong length clamps to MAXLEN
    startCount = 0;
    setReq(3, 7, 48'h30_31_32_33_34_35);
    pushFrame(3);
    bus.Req = 4'b1000;
    waitIdle("len7_frame");
`ifdef TERMINATOR_EN
    chk("len7_starts", 64'(startCount), 64'(8));
`else
    chk("len7_starts", 64'(startCount), 64'(6));
`endif

    // ByteDone during ISSUE must not skip a byte
    glitch = 1'b1;
    setReq(2, 2, 48'h11_22_00_00_00_00);
    pushFrame(2);
    bus.Req = 4'b0100;
    waitIdle("issue_bytedone_ignored");
    glitch = 1'b0;

    // Watchdog abort
    respond = 1'b0;
    setReq(2, 2, 48'h5A_5B_00_00_00_00);
    expByte.push_back(8'h5A);
    bus.Req = 4'b0100;
    n = 0;
    do begin @(negedge Clk); #1; n++; end while (!bus.ByteStart && n < 20);
    t0 = cyc;
    n = 0;
    do begin @(negedge Clk); #1; n++; end while (!bus.TimeoutErr && n < 100);
    chk("timeout_delay", 64'(bus.TimeoutErr ? cyc - t0 : -1), 64'(21));
    chk("timeout_grant_dropped", 64'(bus.Grant), 64'(0));
    chk("timeout_no_framedone", 64'(bus.FrameDone), 64'(0));
    chk("timeout_idle", 64'(bus.Busy), 64'(0));
    @(negedge Clk); #1;
    chk("timeout_pulse_width", 64'(bus.TimeoutErr), 64'(0));
    respond = 1'b1;

    // Served normally after the abort
    setReq(1, 1, 48'h7E_00_00_00_00_00);
    pushFrame(1);
    bus.Req = 4'b0010;
    waitIdle("after_timeout_frame");

    // Reset during WAIT of the second byte
    startCount = 0;
    setReq(0, 3, 48'hC0_C1_C2_00_00_00);
    expByte.push_back(8'hC0);
    expByte.push_back(8'hC1);
    bus.Req = 4'b0001;
    n = 0;
    do begin @(negedge Clk); #1; n++; end while (startCount < 2 && n < 100);
    @(negedge Clk); #1;
    nRst = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({bus.Grant, bus.FrameDone, bus.ByteStart, bus.ByteData,
                                    bus.Busy, bus.TimeoutErr}), 64'(0));
    chk("reset_bytes_consumed", 64'(expByte.size()), 64'(0));
    bus.Req = '0;
    expByte.delete();
    @(negedge Clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      setReq(i, 1, 48'hD0_00_00_00_00_00 | (48'(i) << 40));
      pushFrame(i);
    end
    nRst = 1'b1;
    bus.Req = 4'b1111;
    @(negedge Clk); #1;
    chk("post_reset_priority", 64'(bus.Grant), 64'(4'b0001));
    waitIdle("post_reset_rr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
